// File: rtl/mram_arbiter.sv
// Two-requester arbiter for the single external MRAM port (CPU and SPI programmer).
// Each grant runs a timed SETUP -> STROBE -> HOLD bus cycle; every output is a flop.
module mram_arbiter #(
  parameter int unsigned AW         = 16,
  parameter int unsigned DW         = 32,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic          i_clk,
  input  logic          i_areset,
  input  logic          i_prog_mode,
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wd,
  output logic          o_cpu_ack,
  output logic [DW-1:0] o_cpu_rd,
  input  logic          i_prg_req,
  input  logic          i_prg_we,
  input  logic [AW-1:0] i_prg_addr,
  input  logic [DW-1:0] i_prg_wd,
  output logic          o_prg_ack,
  output logic [DW-1:0] o_prg_rd,
  output logic [AW-1:0] o_maddr,
  output logic [DW-1:0] o_mwd,
  input  logic [DW-1:0] i_mrd,
  output logic          o_we,
  output logic          o_re,
  output logic          o_mdata_oe,
  output logic          o_busy
);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] SetupLd  = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0] StrobeLd = CntW'(STROBE_CYC - 1);
  localparam logic [CntW-1:0] HoldLd   = CntW'(HOLD_CYC - 1);
  localparam logic OwnCpu = 1'b0;
  localparam logic OwnPrg = 1'b1;

  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic            r_owner;
  logic            r_wr;
  logic            r_rr_last;
  logic [AW-1:0]   r_maddr;
  logic [DW-1:0]   r_mwd;
  logic            r_we;
  logic            r_re;
  logic            r_oe;
  logic            r_cpu_ack;
  logic            r_prg_ack;
  logic [DW-1:0]   r_cpu_rd;
  logic [DW-1:0]   r_prg_rd;
  logic            r_busy;

  state_e          w_state_d;
  logic [CntW-1:0] w_cnt_d;
  logic            w_owner_d;
  logic            w_wr_d;
  logic            w_cpu_elig;
  logic            w_prg_elig;
  logic            w_grant;
  logic            w_grant_prg;
  logic            w_cnt_zero;
  logic            w_capture;
  logic            w_we_d;
  logic            w_re_d;
  logic            w_oe_d;
  logic            w_ack_d;
  logic            w_busy_d;

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_owner_d   = r_owner;
    w_wr_d      = r_wr;
    w_grant     = 1'b0;
    w_grant_prg = 1'b0;
    w_capture   = 1'b0;
    w_cpu_elig  = i_cpu_req & ~i_prog_mode;
    w_prg_elig  = i_prg_req;
    w_cnt_zero  = (r_cnt == '0);

    case (r_state)
      StIdle: begin
        if (w_cpu_elig || w_prg_elig) begin
          w_grant = 1'b1;
          // On a tie the side that did not win last time goes first.
          w_grant_prg = w_prg_elig & (~w_cpu_elig | (r_rr_last == OwnCpu));
          w_owner_d   = w_grant_prg ? OwnPrg : OwnCpu;
          w_wr_d      = w_grant_prg ? i_prg_we : i_cpu_we;
          w_state_d   = StSetup;
          w_cnt_d     = SetupLd;
        end
      end
      StSetup: begin
        if (w_cnt_zero) begin
          w_state_d = StStrobe;
          w_cnt_d   = StrobeLd;
        end else begin
          w_cnt_d = r_cnt - CntW'(1);
        end
      end
      StStrobe: begin
        if (w_cnt_zero) begin
          w_capture = ~r_wr;
          w_state_d = StHold;
          w_cnt_d   = HoldLd;
        end else begin
          w_cnt_d = r_cnt - CntW'(1);
        end
      end
      StHold: begin
        if (w_cnt_zero) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt - CntW'(1);
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase

    // Outputs are computed from the next state so they can be registered with no lag.
    w_we_d   = (w_state_d == StStrobe) & w_wr_d;
    w_re_d   = (w_state_d == StStrobe) & ~w_wr_d;
    w_oe_d   = (w_state_d != StIdle) & w_wr_d;
    w_ack_d  = (w_state_d == StHold) & (w_cnt_d == '0);
    w_busy_d = (w_state_d != StIdle);
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_owner   <= OwnCpu;
      r_wr      <= 1'b0;
      r_rr_last <= OwnPrg;
      r_maddr   <= '0;
      r_mwd     <= '0;
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_oe      <= 1'b0;
      r_cpu_ack <= 1'b0;
      r_prg_ack <= 1'b0;
      r_cpu_rd  <= '0;
      r_prg_rd  <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_owner   <= w_owner_d;
      r_wr      <= w_wr_d;
      r_we      <= w_we_d;
      r_re      <= w_re_d;
      r_oe      <= w_oe_d;
      r_cpu_ack <= w_ack_d & (w_owner_d == OwnCpu);
      r_prg_ack <= w_ack_d & (w_owner_d == OwnPrg);
      r_busy    <= w_busy_d;
      if (w_grant) begin
        r_rr_last <= w_grant_prg ? OwnPrg : OwnCpu;
        r_maddr   <= w_grant_prg ? i_prg_addr : i_cpu_addr;
        r_mwd     <= w_grant_prg ? i_prg_wd : i_cpu_wd;
      end
      if (w_capture) begin
        if (r_owner == OwnPrg) begin
          r_prg_rd <= i_mrd;
        end else begin
          r_cpu_rd <= i_mrd;
        end
      end
    end
  end

  assign o_cpu_ack  = r_cpu_ack;
  assign o_prg_ack  = r_prg_ack;
  assign o_cpu_rd   = r_cpu_rd;
  assign o_prg_rd   = r_prg_rd;
  assign o_maddr    = r_maddr;
  assign o_mwd      = r_mwd;
  assign o_we       = r_we;
  assign o_re       = r_re;
  assign o_mdata_oe = r_oe;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_mram_arbiter.sv
// Directed bench for mram_arbiter: default-timing instance plus a SETUP=2/STROBE=3 instance.
module tb_mram_arbiter;

  logic        clk = 1'b0;
  logic        areset;
  logic        prog_mode;
  logic        cpu_req, cpu_we, prg_req, prg_we;
  logic [15:0] cpu_addr, prg_addr;
  logic [31:0] cpu_wd, prg_wd, mrd;
  logic        cpu_ack, prg_ack, we, re, mdata_oe, busy;
  logic [31:0] cpu_rd, prg_rd, mwd;
  logic [15:0] maddr;

  logic        b_req;
  logic [15:0] b_addr;
  logic [31:0] b_mrd;
  logic        b_ack, b_prg_ack, b_we, b_re, b_oe, b_busy;
  logic [31:0] b_rd, b_prg_rd, b_mwd;
  logic [15:0] b_maddr;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc, n_we, n_re, n_overlap, n_chg, n_cpu_ack, n_prg_ack, cpu_ack_cyc;
  int q_order[$];
  logic [15:0] prev_maddr, ack_addr;
  logic [31:0] prev_mwd, ack_wd;

  always #5 clk = ~clk;

  mram_arbiter dut (
    .i_clk(clk), .i_areset(areset), .i_prog_mode(prog_mode),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wd(cpu_wd),
    .o_cpu_ack(cpu_ack), .o_cpu_rd(cpu_rd),
    .i_prg_req(prg_req), .i_prg_we(prg_we), .i_prg_addr(prg_addr), .i_prg_wd(prg_wd),
    .o_prg_ack(prg_ack), .o_prg_rd(prg_rd),
    .o_maddr(maddr), .o_mwd(mwd), .i_mrd(mrd),
    .o_we(we), .o_re(re), .o_mdata_oe(mdata_oe), .o_busy(busy)
  );

  mram_arbiter #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(1)) dut_b (
    .i_clk(clk), .i_areset(areset), .i_prog_mode(1'b0),
    .i_cpu_req(b_req), .i_cpu_we(1'b0), .i_cpu_addr(b_addr), .i_cpu_wd(32'h0),
    .o_cpu_ack(b_ack), .o_cpu_rd(b_rd),
    .i_prg_req(1'b0), .i_prg_we(1'b0), .i_prg_addr(16'h0), .i_prg_wd(32'h0),
    .o_prg_ack(b_prg_ack), .o_prg_rd(b_prg_rd),
    .o_maddr(b_maddr), .o_mwd(b_mwd), .i_mrd(b_mrd),
    .o_we(b_we), .o_re(b_re), .o_mdata_oe(b_oe), .o_busy(b_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    cyc = 0; n_we = 0; n_re = 0; n_cpu_ack = 0; n_prg_ack = 0; cpu_ack_cyc = 0;
    q_order.delete();
  endtask

  // Advance one clock, sample 1 time unit after the edge, drop a request once it is acked.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (we && re) n_overlap++;
    if ((we || re) && (maddr !== prev_maddr || mwd !== prev_mwd)) n_chg++;
    prev_maddr = maddr;
    prev_mwd   = mwd;
    if (we) n_we++;
    if (re) n_re++;
    if (cpu_ack) begin
      n_cpu_ack++; cpu_ack_cyc = cyc; q_order.push_back(0);
      ack_addr = maddr; ack_wd = mwd; cpu_req = 1'b0;
    end
    if (prg_ack) begin
      n_prg_ack++; q_order.push_back(1);
      ack_addr = maddr; ack_wd = mwd; prg_req = 1'b0;
    end
  endtask

  task automatic wait_done(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (!cpu_req && !prg_req) break;
      step();
    end
    check("xfer_done", {62'd0, cpu_req, prg_req}, 64'd0);
  endtask

  initial begin
    int lat, rcnt;
    areset = 1'b1; prog_mode = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wd = 0;
    prg_req = 0; prg_we = 0; prg_addr = 0; prg_wd = 0; mrd = 0;
    b_req = 0; b_addr = 0; b_mrd = 0;
    n_overlap = 0; n_chg = 0; prev_maddr = 0; prev_mwd = 0; ack_addr = 0; ack_wd = 0;
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {30'd0, cpu_ack, prg_ack, we, re, mdata_oe, busy, maddr}, 64'd0);
    check("reset_rd", {cpu_rd, prg_rd}, 64'd0);
    #2 areset = 1'b0;

    // Simultaneous writes: CPU first after reset, then programmer, every round.
    for (int r = 0; r < 4; r++) begin
      clear_counts();
      cpu_we = 1; cpu_addr = 16'h0100 + 16'(r); cpu_wd = 32'hC0000000 + r;
      prg_we = 1; prg_addr = 16'h0200 + 16'(r); prg_wd = 32'hB0000000 + r;
      cpu_req = 1; prg_req = 1;
      wait_done(30);
      check("rr_count", 64'(q_order.size()), 64'd2);
      check("rr_first_cpu", 64'(q_order[0]), 64'd0);
      check("rr_second_prg", 64'(q_order[1]), 64'd1);
      check("rr_we_cycles", 64'(n_we), 64'd4);
      step();
    end

    // CPU read with default timing.
    clear_counts();
    cpu_we = 0; cpu_addr = 16'h0010; mrd = 32'hDEADBEEF; cpu_req = 1;
    wait_done(20);
    check("rd_latency", 64'(cpu_ack_cyc), 64'd4);
    check("rd_re_cycles", 64'(n_re), 64'd2);
    check("rd_addr", 64'(ack_addr), 64'h0010);
    check("rd_cpu_rd", 64'(cpu_rd), 64'hDEADBEEF);
    check("rd_prg_rd_untouched", 64'(prg_rd), 64'd0);
    step();

    // CPU just won, so a tie now goes to the programmer.
    clear_counts();
    mrd = 32'h11112222;
    prg_we = 0; prg_addr = 16'h0033; cpu_addr = 16'h0044;
    cpu_req = 1; prg_req = 1;
    wait_done(30);
    check("fair_first_prg", 64'(q_order[0]), 64'd1);
    check("fair_prg_rd", 64'(prg_rd), 64'h11112222);
    check("fair_cpu_rd", 64'(cpu_rd), 64'h11112222);
    step();

    // prog_mode holds off the CPU until it is cleared.
    clear_counts();
    mrd = 32'h5A5A0001;
    prog_mode = 1; cpu_we = 0; cpu_addr = 16'h0020; cpu_req = 1;
    prg_we = 1; prg_addr = 16'h1234; prg_wd = 32'hA5A5A5A5; prg_req = 1;
    repeat (12) step();
    check("pm_prg_acks", 64'(n_prg_ack), 64'd1);
    check("pm_cpu_acks", 64'(n_cpu_ack), 64'd0);
    check("pm_addr", 64'(ack_addr), 64'h1234);
    check("pm_wd", 64'(ack_wd), 64'hA5A5A5A5);
    prog_mode = 0;
    wait_done(20);
    check("pm_cpu_after", 64'(n_cpu_ack), 64'd1);
    check("pm_cpu_rd", 64'(cpu_rd), 64'h5A5A0001);
    step();

    // Back-to-back CPU writes with exactly one idle cycle between them.
    clear_counts();
    cpu_we = 1;
    for (int i = 0; i < 4; i++) begin
      cpu_addr = 16'(i); cpu_wd = 32'h100 + i; cpu_req = 1;
      wait_done(20);
      check("b2b_addr", 64'(ack_addr), 64'(i));
      step();
      check("b2b_idle", {62'd0, busy, cpu_ack}, 64'd0);
    end
    check("b2b_we_cycles", 64'(n_we), 64'd8);
    check("b2b_rd_kept", 64'(cpu_rd), 64'h5A5A0001);

    // Asynchronous reset in the middle of a write strobe.
    clear_counts();
    cpu_we = 1; cpu_addr = 16'h0055; cpu_wd = 32'h77; cpu_req = 1;
    step();
    check("rst_setup_oe", {62'd0, mdata_oe, we}, 64'd2);
    step();
    check("rst_strobe_we", {62'd0, mdata_oe, we}, 64'd3);
    #1 areset = 1'b1;
    #1;
    check("rst_async_drop", {60'd0, we, re, mdata_oe, busy}, 64'd0);
    cpu_req = 0;
    #1 areset = 1'b0;
    repeat (4) step();
    check("rst_no_ack", 64'(n_cpu_ack), 64'd0);

    // Longer timing instance: SETUP=2, STROBE=3.
    lat = 0; rcnt = 0;
    b_addr = 16'h0040; b_mrd = 32'h0BADF00D; b_req = 1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (b_re) rcnt++;
      if (b_ack) begin
        lat = i; b_req = 0;
        break;
      end
    end
    check("slow_latency", 64'(lat), 64'd6);
    check("slow_re_cycles", 64'(rcnt), 64'd3);
    check("slow_rd", 64'(b_rd), 64'h0BADF00D);

    check("never_we_and_re", 64'(n_overlap), 64'd0);
    check("no_bus_change_in_strobe", 64'(n_chg), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
